operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Issue/operand-fetch stage between instruction decode and execute in the 32-bit pipelined core.
- Drives the register-file read addresses and captures the operands.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards.
- Forwards same-cycle writeback data, then presents operands to EX through a 1-entry valid/ready output register.

Parameters:
DATA_W, 32, operand/writeback data width
REG_AW, 4, register index width (16 architectural registers; register 0 reads as zero and is never written)
CTRL_W, 16, opaque decoded-control bundle width, passed through unchanged

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-low (asserted when 0)
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts this cycle
in_rs1  in  REG_AW  source register 1
in_rs2  in  REG_AW  source register 2
in_rd  in  REG_AW  destination register
in_rd_we  in  1  instruction writes in_rd
in_ctrl  in  CTRL_W  decoded control
rf_rd_reg1  out  REG_AW  register-file read address 1; equals in_rs1, combinational
rf_rd_reg2  out  REG_AW  register-file read address 2; equals in_rs2, combinational
rf_rd_data1  in  DATA_W  register-file read data 1 (combinational read)
rf_rd_data2  in  DATA_W  register-file read data 2
wb_en  in  1  writeback this cycle (same signal drives the register-file write enable)
wb_reg  in  REG_AW  writeback register
wb_data  in  DATA_W  writeback data
flush  in  1  kill the entry held in the output register
out_valid  out  1  operands valid to EX
out_ready  in  1  EX accepts
out_op1  out  DATA_W  operand 1
out_op2  out  DATA_W  operand 2
out_rd  out  REG_AW  destination register
out_rd_we  out  1  destination write enable
out_ctrl  out  CTRL_W  control passthrough
busy  out  1  scoreboard non-zero

Behaviour:
- Reset (rst=0, async) clears out_valid, out_op1/out_op2/out_rd/out_rd_we/out_ctrl to 0, the scoreboard pend[15:0] to 0, and busy to 0.
- wbclr(r) = wb_en & wb_reg==r & r!=0. pending(r) = pend[r] & ~wbclr(r). Register 0 is never pending.
- raw = pending(in_rs1) | pending(in_rs2). waw = in_rd_we & in_rd!=0 & pending(in_rd).
- in_ready = (~out_valid | out_ready) & ~raw & ~waw & ~flush. An accept ("fire") is in_valid & in_ready.
- Operand selection: 0 if rs==0; else wb_data if wbclr(rs); else rf_rd_dataN.
- On fire, the output register loads the selected operands, in_rd, in_rd_we and in_ctrl, and out_valid goes to 1. Latency is 1 cycle.
- Without fire: out_valid drops on out_ready; otherwise it holds and the output fields stay stable.
- Scoreboard, per cycle:
  - Set pend[in_rd] on fire when in_rd_we & in_rd!=0.
  - Clear pend[wb_reg] on wbclr.
  - If set and clear target the same register, set wins; the WAW rule means this occurs only for a new writer.
- flush=1: out_valid goes to 0 next cycle. If the killed entry has out_rd_we & out_rd!=0, its pend bit is cleared; that clear also wins over any set to the same register. No accept occurs that cycle. Instructions already past EX still write back.
- The WAW stall guarantees at most one in-flight writer per register, so a single bit per register is sufficient.
- busy = |pend, registered.
- wb_en with a wb_reg that is not pending is legal and has no scoreboard effect.

Optional Feature:
- OPF_WB_BYPASS_EN defined: the same-cycle writeback forwarding described above, and pending() excludes wbclr.
- Not defined: pending(r)=pend[r] and operands always come from the register file. A consumer stalls until the cycle after writeback, which costs one extra cycle per RAW hazard.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_AW and DATA_W
  - NREGS=16
  - ZERO_REG=0
  - the ctrl bundle width constant
- One sub-module, opf_scoreboard, contains the pend register, the set/clear/flush-clear logic and the pending/raw/waw outputs.
- Operand muxing and the output register stay in the top module.

Test Plan:
- Reset: hold rst=0 with random inputs -> out_valid=0, busy=0, all outputs 0; release rst -> in_ready=1.
- Independent stream:
  - stimulus: issue r3<-(r1,r2) with rf data 0x11/0x22, out_ready=1
  - response: next cycle out_op1=0x11, out_op2=0x22, out_rd=3, pend[3]=1
- RAW via bypass:
  - stimulus: issue r5 writer, then a reader of r5; wb_en=1, wb_reg=5, wb_data=0xDEADBEEF in the reader's cycle
  - response: the reader fires that cycle and out_op1=0xDEADBEEF
  - without OPF_WB_BYPASS_EN: the reader stalls 1 cycle and takes the RF value
- WAW plus backpressure:
  - stimulus: pending r7, new writer to r7, out_ready=0
  - response: in_ready=0; the output holds stable until out_ready=1 and wb r7
- Flush: entry writing r9 in the output register, flush=1 -> out_valid=0 next cycle, pend[9]=0, no accept that cycle.
- Zero register: rs1=0 and in_rd=0 with in_rd_we=1 -> op1=0, no stall, scoreboard unchanged; wb_en to r0 has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 32-bit pipelined core.
// Widths, register-file geometry and the decoded-control bundle size.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 4;
    localparam int NREGS    = 16;
    localparam int ZERO_REG = 0;
    localparam int CTRL_W   = 16;

endpackage

// File: rtl/opf_scoreboard.sv
// Pending-writer scoreboard for the operand-fetch stage: one bit per register.
// Optional macro OPF_WB_BYPASS_EN lets a same-cycle writeback hide the pend bit.
module opf_scoreboard #(
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              rd_we,
    input  logic              fire,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic              kill,
    input  logic [REG_AW-1:0] kill_rd,
    output logic              raw,
    output logic              waw,
    output logic              busy
);
    import cpu_pkg::*;

    localparam int NR = 1 << REG_AW;

    logic [NR-1:0] pend;
    logic [NR-1:0] pend_d;
    logic [NR-1:0] wbclr;
    logic [NR-1:0] set_v;
    logic [NR-1:0] kill_v;
    logic [NR-1:0] eff;

    // Register 0 is skipped by the loop, so it can never become pending.
    always_comb begin
        wbclr  = '0;
        set_v  = '0;
        kill_v = '0;
        for (int i = ZERO_REG + 1; i < NR; i++) begin
            wbclr[i]  = wb_en & (wb_reg == REG_AW'(i));
            set_v[i]  = fire & rd_we & (rd == REG_AW'(i));
            kill_v[i] = kill & (kill_rd == REG_AW'(i));
        end
        pend_d = ((pend & ~wbclr) | set_v) & ~kill_v;
    end

`ifdef OPF_WB_BYPASS_EN
    assign eff = pend & ~wbclr;
`else
    assign eff = pend;
`endif

    assign raw = eff[rs1] | eff[rs2];
    assign waw = rd_we & (rd != REG_AW'(ZERO_REG)) & eff[rd];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
            busy <= 1'b0;
        end else begin
            pend <= pend_d;
            busy <= |pend_d;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Issue/operand-fetch stage: RF read, hazard stall, 1-entry output register.
// Optional macro OPF_WB_BYPASS_EN forwards same-cycle writeback data.
module operand_fetch_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CTRL_W = cpu_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [REG_AW-1:0] rf_rd_reg1,
    output logic [REG_AW-1:0] rf_rd_reg2,
    input  logic [DATA_W-1:0] rf_rd_data1,
    input  logic [DATA_W-1:0] rf_rd_data2,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_rd_we,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              busy
);
    import cpu_pkg::*;

    logic              raw;
    logic              waw;
    logic              fire;
    logic              kill;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    assign rf_rd_reg1 = in_rs1;
    assign rf_rd_reg2 = in_rs2;

    assign in_ready = (~out_valid | out_ready) & ~raw & ~waw & ~flush;
    assign fire     = in_valid & in_ready;
    assign kill     = flush & out_valid & out_rd_we;

    opf_scoreboard #(
        .REG_AW (REG_AW)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .rd      (in_rd),
        .rd_we   (in_rd_we),
        .fire    (fire),
        .wb_en   (wb_en),
        .wb_reg  (wb_reg),
        .kill    (kill),
        .kill_rd (out_rd),
        .raw     (raw),
        .waw     (waw),
        .busy    (busy)
    );

    // Zero-register check comes last so it overrides any forwarded value.
    always_comb begin
        op1 = rf_rd_data1;
        op2 = rf_rd_data2;
`ifdef OPF_WB_BYPASS_EN
        if (wb_en && wb_reg == in_rs1) op1 = wb_data;
        if (wb_en && wb_reg == in_rs2) op2 = wb_data;
`endif
        if (in_rs1 == REG_AW'(ZERO_REG)) op1 = '0;
        if (in_rs2 == REG_AW'(ZERO_REG)) op2 = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_op1   <= op1;
            out_op2   <= op2;
            out_rd    <= in_rd;
            out_rd_we <= in_rd_we;
            out_ctrl  <= in_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: vector table plus hazard sequences.
// Expectations follow OPF_WB_BYPASS_EN when it is defined for the build.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_rs1 = '0;
    logic [3:0]  in_rs2 = '0;
    logic [3:0]  in_rd = '0;
    logic        in_rd_we = 1'b0;
    logic [15:0] in_ctrl = '0;
    logic [3:0]  rf_rd_reg1;
    logic [3:0]  rf_rd_reg2;
    logic [31:0] rf_rd_data1 = '0;
    logic [31:0] rf_rd_data2 = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [3:0]  out_rd;
    logic        out_rd_we;
    logic [15:0] out_ctrl;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_rd_we    (in_rd_we),
        .in_ctrl     (in_ctrl),
        .rf_rd_reg1  (rf_rd_reg1),
        .rf_rd_reg2  (rf_rd_reg2),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_ctrl    (out_ctrl),
        .busy        (busy)
    );

    typedef struct {
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic        we;
        logic [15:0] ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tv[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic we,
                         input logic [15:0] ctrl, input logic [31:0] d1,
                         input logic [31:0] d2);
        in_valid    = 1'b1;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_rd       = rd;
        in_rd_we    = we;
        in_ctrl     = ctrl;
        rf_rd_data1 = d1;
        rf_rd_data2 = d2;
    endtask

    task automatic quiet();
        in_valid = 1'b0;
        in_rd_we = 1'b0;
        wb_en    = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        tv[0] = '{4'd1, 4'd2, 4'd0, 1'b0, 16'h1111,
                  32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000};
        tv[1] = '{4'd0, 4'd15, 4'd15, 1'b0, 16'hFFFF,
                  32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'h1234_5678};
        tv[2] = '{4'd15, 4'd0, 4'd0, 1'b1, 16'h0000,
                  32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h0};
        tv[3] = '{4'd8, 4'd8, 4'd1, 1'b0, 16'h8001,
                  32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE};
        tv[4] = '{4'd0, 4'd0, 4'd0, 1'b1, 16'h1234,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};

        // reset with random activity on the inputs
        for (int i = 0; i < 3; i++) begin
            in_valid    = 1'($urandom);
            in_rs1      = 4'($urandom);
            in_rs2      = 4'($urandom);
            in_rd       = 4'($urandom);
            in_rd_we    = 1'($urandom);
            in_ctrl     = 16'($urandom);
            rf_rd_data1 = $urandom;
            rf_rd_data2 = $urandom;
            wb_en       = 1'($urandom);
            wb_reg      = 4'($urandom);
            wb_data     = $urandom;
            flush       = 1'($urandom);
            out_ready   = 1'($urandom);
            tick();
        end
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op1", out_op1, 32'd0);
        chk("rst_op2", out_op2, 32'd0);
        chk("rst_rd", 32'(out_rd), 32'd0);
        chk("rst_rd_we", 32'(out_rd_we), 32'd0);
        chk("rst_ctrl", 32'(out_ctrl), 32'd0);
        quiet();
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // independent vectors on an empty scoreboard
        for (int i = 0; i < 5; i++) begin
            issue(tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].we, tv[i].ctrl,
                  tv[i].d1, tv[i].d2);
            #1;
            chk("tv_in_ready", 32'(in_ready), 32'd1);
            chk("tv_rf_reg1", 32'(rf_rd_reg1), 32'(tv[i].rs1));
            chk("tv_rf_reg2", 32'(rf_rd_reg2), 32'(tv[i].rs2));
            tick();
            chk("tv_valid", 32'(out_valid), 32'd1);
            chk("tv_op1", out_op1, tv[i].e1);
            chk("tv_op2", out_op2, tv[i].e2);
            chk("tv_rd", 32'(out_rd), 32'(tv[i].rd));
            chk("tv_rd_we", 32'(out_rd_we), 32'(tv[i].we));
            chk("tv_ctrl", 32'(out_ctrl), 32'(tv[i].ctrl));
            chk("tv_busy", 32'(busy), 32'd0);
        end

        // r3 <- (r1, r2)
        issue(4'd1, 4'd2, 4'd3, 1'b1, 16'hA5A5, 32'h11, 32'h22);
        #1;
        chk("ind_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("ind_valid", 32'(out_valid), 32'd1);
        chk("ind_op1", out_op1, 32'h11);
        chk("ind_op2", out_op2, 32'h22);
        chk("ind_rd", 32'(out_rd), 32'd3);
        chk("ind_ctrl", 32'(out_ctrl), 32'hA5A5);
        chk("ind_busy", 32'(busy), 32'd1);
        issue(4'd3, 4'd0, 4'd4, 1'b0, 16'h0, 32'h33, 32'h0);
        #1;
        chk("raw3_stall", 32'(in_ready), 32'd0);
        tick();
        chk("raw3_drain", 32'(out_valid), 32'd0);
        chk("raw3_busy", 32'(busy), 32'd1);
        quiet();
        wb_en = 1'b1; wb_reg = 4'd3; wb_data = 32'h33;
        tick();
        chk("wb3_busy", 32'(busy), 32'd0);

        // RAW on r5 resolved by writeback
        quiet();
        issue(4'd1, 4'd2, 4'd5, 1'b1, 16'h0505, 32'h1, 32'h2);
        tick();
        chk("w5_busy", 32'(busy), 32'd1);
        issue(4'd5, 4'd0, 4'd6, 1'b0, 16'h0606, 32'h0BAD_0BAD, 32'h0);
        wb_en = 1'b1; wb_reg = 4'd5; wb_data = 32'hDEAD_BEEF;
        #1;
`ifdef OPF_WB_BYPASS_EN
        chk("byp_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("byp_valid", 32'(out_valid), 32'd1);
        chk("byp_op1", out_op1, 32'hDEAD_BEEF);
        chk("byp_busy", 32'(busy), 32'd0);
`else
        chk("nobyp_stall", 32'(in_ready), 32'd0);
        tick();
        chk("nobyp_drain", 32'(out_valid), 32'd0);
        chk("nobyp_busy", 32'(busy), 32'd0);
        wb_en = 1'b0;
        rf_rd_data1 = 32'hDEAD_BEEF;
        #1;
        chk("nobyp_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("nobyp_valid", 32'(out_valid), 32'd1);
        chk("nobyp_op1", out_op1, 32'hDEAD_BEEF);
`endif
        wb_en = 1'b0;

        // WAW on r7 with backpressure
        issue(4'd0, 4'd0, 4'd7, 1'b1, 16'h0707, 32'h99, 32'h99);
        tick();
        chk("w7_rd", 32'(out_rd), 32'd7);
        chk("w7_op1", out_op1, 32'h0);
        chk("w7_busy", 32'(busy), 32'd1);
        issue(4'd1, 4'd0, 4'd7, 1'b1, 16'h7777, 32'h71, 32'h0);
        out_ready = 1'b0;
        #1;
        chk("waw_bp_stall", 32'(in_ready), 32'd0);
        tick();
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_ctrl", 32'(out_ctrl), 32'h0707);
        chk("bp_rd", 32'(out_rd), 32'd7);
        out_ready = 1'b1;
        #1;
        chk("waw_stall", 32'(in_ready), 32'd0);
        tick();
        chk("waw_drain", 32'(out_valid), 32'd0);
        wb_en = 1'b1; wb_reg = 4'd7; wb_data = 32'h77;
        #1;
`ifdef OPF_WB_BYPASS_EN
        chk("waw_wb_ready", 32'(in_ready), 32'd1);
        tick();
        chk("waw_valid", 32'(out_valid), 32'd1);
        chk("waw_ctrl", 32'(out_ctrl), 32'h7777);
        chk("waw_op1", out_op1, 32'h71);
        chk("waw_set_wins", 32'(busy), 32'd1);
`else
        chk("waw_wb_stall", 32'(in_ready), 32'd0);
        tick();
        chk("waw_wb_busy", 32'(busy), 32'd0);
        wb_en = 1'b0;
        #1;
        chk("waw_ready", 32'(in_ready), 32'd1);
        tick();
        chk("waw_ctrl", 32'(out_ctrl), 32'h7777);
        chk("waw_busy", 32'(busy), 32'd1);
`endif
        quiet();
        wb_en = 1'b1; wb_reg = 4'd7;
        tick();
        chk("wb7_busy", 32'(busy), 32'd0);
        chk("wb7_drain", 32'(out_valid), 32'd0);

        // flush kills r9 writer held in the output register
        quiet();
        issue(4'd1, 4'd2, 4'd9, 1'b1, 16'h0909, 32'h1, 32'h2);
        tick();
        chk("w9_rd", 32'(out_rd), 32'd9);
        chk("w9_busy", 32'(busy), 32'd1);
        issue(4'd1, 4'd2, 4'd10, 1'b1, 16'h0A0A, 32'h1, 32'h2);
        flush = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("flush_no_accept", 32'(in_ready), 32'd0);
        tick();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        issue(4'd9, 4'd9, 4'd0, 1'b0, 16'h0D0D, 32'h123, 32'h456);
        #1;
        chk("flush_r9_free", 32'(in_ready), 32'd1);
        tick();
        chk("r9_valid", 32'(out_valid), 32'd1);
        chk("r9_op1", out_op1, 32'h123);
        chk("r9_ctrl", 32'(out_ctrl), 32'h0D0D);

        // zero register
        issue(4'd0, 4'd2, 4'd0, 1'b1, 16'h0E0E, 32'hFFFF_FFFF, 32'h1234);
        #1;
        chk("z_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("z_op1", out_op1, 32'h0);
        chk("z_op2", out_op2, 32'h1234);
        chk("z_rd_we", 32'(out_rd_we), 32'd1);
        chk("z_busy", 32'(busy), 32'd0);
        issue(4'd0, 4'd0, 4'd0, 1'b1, 16'h0F0F, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wb_en = 1'b1; wb_reg = 4'd0; wb_data = 32'hCAFE;
        #1;
        chk("z_wb_ready", 32'(in_ready), 32'd1);
        tick();
        chk("z_wb_op1", out_op1, 32'h0);
        chk("z_wb_op2", out_op2, 32'h0);
        chk("z_wb_busy", 32'(busy), 32'd0);

        // asynchronous reset between clock edges
        quiet();
        issue(4'd1, 4'd2, 4'd11, 1'b1, 16'h0B0B, 32'h5, 32'h6);
        tick();
        chk("pre_arst_busy", 32'(busy), 32'd1);
        quiet();
        #1;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rd", 32'(out_rd), 32'd0);
        rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
